// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC sequencer.
//   state_t : sequencer FSM states
//   tag_t   : {valid, last, row, col} carried alongside each issued term
//   acc_w() : accumulator width for a given operand width / inner dimension
//   idx_w() : index width for a count of entries, never below 1 bit
package mac_pkg;

    function automatic int unsigned idx_w(input int unsigned entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

    function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned k_max);
        return 2 * data_w + $clog2(k_max) + 1;
    endfunction

    // Default matrix limits; the tag index fields are sized from these.
    localparam int unsigned M_MAX_DEF = 4;
    localparam int unsigned N_MAX_DEF = 4;
    localparam int unsigned TAG_ROW_W = idx_w(M_MAX_DEF);
    localparam int unsigned TAG_COL_W = idx_w(N_MAX_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic                 last;
        logic [TAG_ROW_W-1:0] row;
        logic [TAG_COL_W-1:0] col;
    } tag_t;

endpackage

// File: rtl/mac_seq_ctrl_tag_pipe.sv
// Fixed-depth shift register of result tags, cleared by synchronous reset.
//   clk, rst  : clock, synchronous active-high reset
//   din       : tag entering the pipe this cycle
//   dout      : tag leaving the pipe (last stage, registered)
//   in_flight : a valid tag sits in any stage other than the last
module mac_tag_pipe
    import mac_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  tag_t din,
    output tag_t dout,
    output logic in_flight
);

    // Mask of every stage except the output stage.
    localparam logic [DEPTH-1:0] EARLY_MASK = {DEPTH{1'b1}} >> 1;

    tag_t             stage [DEPTH];
    logic [DEPTH-1:0] stage_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage[0] <= '0;
        end else begin
            stage[0] <= din;
        end
    end

    for (genvar d = 1; d < DEPTH; d++) begin : g_stage
        always_ff @(posedge clk) begin
            if (rst) begin
                stage[d] <= '0;
            end else begin
                stage[d] <= stage[d-1];
            end
        end
    end

    for (genvar d = 0; d < DEPTH; d++) begin : g_vld
        assign stage_vld[d] = stage[d].valid;
    end

    assign dout      = stage[DEPTH-1];
    assign in_flight = |(stage_vld & EARLY_MASK);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one pipelined MAC computing C = A x B from two read-only
// operand memories; walks i/j/k (k innermost), one term per cycle.
//   start, cfg_m/k/n      : run request and dimensions (sampled with start)
//   a_rd_*, b_rd_*        : operand memory reads (1-cycle latency)
//   mac_en, mac_clear     : MAC operand-valid and accumulator-load strobes
//   acc_out / res_*       : MAC result in, tagged result out
//   busy, done, cfg_err   : run status
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter  int unsigned DATA_W  = 16,
    parameter  int unsigned K_MAX   = 4,
    parameter  int unsigned M_MAX   = M_MAX_DEF,
    parameter  int unsigned N_MAX   = N_MAX_DEF,
    parameter  int unsigned MAC_LAT = 2,
    localparam int unsigned ACC_W   = acc_w(DATA_W, K_MAX),
    localparam int unsigned MW      = $clog2(M_MAX + 1),
    localparam int unsigned KW      = $clog2(K_MAX + 1),
    localparam int unsigned NW      = $clog2(N_MAX + 1),
    localparam int unsigned AAW     = idx_w(M_MAX * K_MAX),
    localparam int unsigned BAW     = idx_w(K_MAX * N_MAX),
    localparam int unsigned RW      = idx_w(M_MAX),
    localparam int unsigned CW      = idx_w(N_MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [MW-1:0]    cfg_m,
    input  logic [KW-1:0]    cfg_k,
    input  logic [NW-1:0]    cfg_n,
    output logic             a_rd_en,
    output logic [AAW-1:0]   a_rd_addr,
    output logic             b_rd_en,
    output logic [BAW-1:0]   b_rd_addr,
    output logic             mac_en,
    output logic             mac_clear,
    input  logic [ACC_W-1:0] acc_out,
    output logic             res_valid,
    output logic [RW-1:0]    res_row,
    output logic [CW-1:0]    res_col,
    output logic [ACC_W-1:0] res_data,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    // Tag leaves the pipe one memory cycle plus MAC_LAT after issue.
    localparam int unsigned PIPE_DEPTH = 1 + MAC_LAT;

    state_t         state;
    logic [MW-1:0]  m_lat;
    logic [KW-1:0]  k_lat;
    logic [NW-1:0]  n_lat;
    logic [MW-1:0]  cnt_i;
    logic [KW-1:0]  cnt_k;
    logic [NW-1:0]  cnt_j;
    logic [AAW-1:0] a_base;
    logic           cfg_ok;
    logic           k_last;
    logic           j_last;
    logic           i_last;
    logic           in_flight;
    tag_t           iss_tag;
    tag_t           out_tag;

    assign cfg_ok = (cfg_m != '0) && (cfg_m <= MW'(M_MAX)) &&
                    (cfg_k != '0) && (cfg_k <= KW'(K_MAX)) &&
                    (cfg_n != '0) && (cfg_n <= NW'(N_MAX));

    assign k_last = (cnt_k == KW'(k_lat - KW'(1)));
    assign j_last = (cnt_j == NW'(n_lat - NW'(1)));
    assign i_last = (cnt_i == MW'(m_lat - MW'(1)));

    // Tag for the term currently presented to the operand memories.
    always_comb begin
        iss_tag       = '0;
        iss_tag.valid = a_rd_en;
        iss_tag.last  = k_last;
        iss_tag.row   = TAG_ROW_W'(cnt_i);
        iss_tag.col   = TAG_COL_W'(cnt_j);
    end

    mac_tag_pipe #(
        .DEPTH (PIPE_DEPTH)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .din       (iss_tag),
        .dout      (out_tag),
        .in_flight (in_flight)
    );

    assign res_valid = out_tag.valid & out_tag.last;
    assign res_row   = RW'(out_tag.row);
    assign res_col   = CW'(out_tag.col);
    assign res_data  = acc_out;

    // Sequencer FSM, loop counters and incremental address generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            m_lat     <= '0;
            k_lat     <= '0;
            n_lat     <= '0;
            cnt_i     <= '0;
            cnt_j     <= '0;
            cnt_k     <= '0;
            a_base    <= '0;
            a_rd_en   <= 1'b0;
            b_rd_en   <= 1'b0;
            a_rd_addr <= '0;
            b_rd_addr <= '0;
            mac_en    <= 1'b0;
            mac_clear <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            // Memory data arrives one cycle after the read strobe.
            mac_en    <= a_rd_en;
            mac_clear <= a_rd_en && (cnt_k == '0);
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            state     <= RUN;
                            m_lat     <= cfg_m;
                            k_lat     <= cfg_k;
                            n_lat     <= cfg_n;
                            cnt_i     <= '0;
                            cnt_j     <= '0;
                            cnt_k     <= '0;
                            a_base    <= '0;
                            a_rd_en   <= 1'b1;
                            b_rd_en   <= 1'b1;
                            a_rd_addr <= '0;
                            b_rd_addr <= '0;
                            busy      <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!k_last) begin
                        cnt_k     <= KW'(cnt_k + KW'(1));
                        a_rd_addr <= AAW'(a_rd_addr + AAW'(1));
                        b_rd_addr <= BAW'(b_rd_addr + BAW'(n_lat));
                    end else begin
                        cnt_k <= '0;
                        if (!j_last) begin
                            // Next column: restart the A row, B at (k=0, j+1).
                            cnt_j     <= NW'(cnt_j + NW'(1));
                            a_rd_addr <= a_base;
                            b_rd_addr <= BAW'(BAW'(cnt_j) + BAW'(1));
                        end else begin
                            cnt_j <= '0;
                            if (!i_last) begin
                                cnt_i     <= MW'(cnt_i + MW'(1));
                                a_base    <= AAW'(a_base + AAW'(k_lat));
                                a_rd_addr <= AAW'(a_base + AAW'(k_lat));
                                b_rd_addr <= '0;
                            end else begin
                                state     <= DRAIN;
                                cnt_i     <= '0;
                                a_base    <= '0;
                                a_rd_en   <= 1'b0;
                                b_rd_en   <= 1'b0;
                                a_rd_addr <= '0;
                                b_rd_addr <= '0;
                            end
                        end
                    end
                end
                DRAIN: begin
                    // Only the output stage may still hold a tag: it leaves this cycle.
                    if (!in_flight) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Testbench for mac_seq_ctrl: operand memories and a 2-stage MAC around the
// DUT, expected behaviour derived from the matrix product and cycle formulas.
module tb_mac_seq_ctrl;

    localparam int MAC_LAT = 2;
    localparam int ACC_W   = 35;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       cfg_m;
    logic [2:0]       cfg_k;
    logic [2:0]       cfg_n;
    logic             a_rd_en;
    logic [3:0]       a_rd_addr;
    logic             b_rd_en;
    logic [3:0]       b_rd_addr;
    logic             mac_en;
    logic             mac_clear;
    logic [ACC_W-1:0] acc_out;
    logic             res_valid;
    logic [1:0]       res_row;
    logic [1:0]       res_col;
    logic [ACC_W-1:0] res_data;
    logic             busy;
    logic             done;
    logic             cfg_err;

    logic signed [15:0] am [16];
    logic signed [15:0] bm [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_m     (cfg_m),
        .cfg_k     (cfg_k),
        .cfg_n     (cfg_n),
        .a_rd_en   (a_rd_en),
        .a_rd_addr (a_rd_addr),
        .b_rd_en   (b_rd_en),
        .b_rd_addr (b_rd_addr),
        .mac_en    (mac_en),
        .mac_clear (mac_clear),
        .acc_out   (acc_out),
        .res_valid (res_valid),
        .res_row   (res_row),
        .res_col   (res_col),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    // Operand memories with 1-cycle read latency.
    logic signed [15:0] a_q;
    logic signed [15:0] b_q;
    always @(posedge clk) begin
        if (a_rd_en) a_q <= am[a_rd_addr];
        if (b_rd_en) b_q <= bm[b_rd_addr];
    end

    // MAC: product register, then accumulator (two cycles to acc_out).
    logic signed [31:0]      p1;
    logic                    p1_en;
    logic                    p1_clr;
    logic signed [ACC_W-1:0] acc;
    always @(posedge clk) begin
        if (rst) begin
            p1     <= '0;
            p1_en  <= 1'b0;
            p1_clr <= 1'b0;
            acc    <= '0;
        end else begin
            p1     <= a_q * b_q;
            p1_en  <= mac_en;
            p1_clr <= mac_clear;
            if (p1_en) acc <= p1_clr ? ACC_W'(p1) : acc + ACC_W'(p1);
        end
    end
    assign acc_out = acc;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " a_rd_en"},   longint'(a_rd_en),   0);
        check({tag, " b_rd_en"},   longint'(b_rd_en),   0);
        check({tag, " a_rd_addr"}, longint'(a_rd_addr), 0);
        check({tag, " b_rd_addr"}, longint'(b_rd_addr), 0);
        check({tag, " mac_en"},    longint'(mac_en),    0);
        check({tag, " mac_clear"}, longint'(mac_clear), 0);
        check({tag, " res_valid"}, longint'(res_valid), 0);
        check({tag, " res_row"},   longint'(res_row),   0);
        check({tag, " res_col"},   longint'(res_col),   0);
        check({tag, " busy"},      longint'(busy),      0);
        check({tag, " done"},      longint'(done),      0);
        check({tag, " cfg_err"},   longint'(cfg_err),   0);
    endtask

    task automatic fill_rand();
        for (int x = 0; x < 16; x++) begin
            am[x] = 16'($urandom);
            bm[x] = 16'($urandom);
        end
    endtask

    // Start a run in the current cycle and check every cycle until it is idle again.
    task automatic run_job(input int m, input int k, input int n, input bit poke);
        longint cm [4][4];
        longint e_rd [96], e_aa [96], e_ba [96], e_men [96], e_clr [96];
        longint e_val [96], e_row [96], e_col [96], e_dat [96], e_done [96], e_busy [96];
        int t;
        int nt;
        int r_end;
        for (int r = 0; r < 96; r++) begin
            e_rd[r] = 0; e_aa[r] = 0; e_ba[r] = 0; e_men[r] = 0; e_clr[r] = 0;
            e_val[r] = 0; e_row[r] = 0; e_col[r] = 0; e_dat[r] = 0; e_done[r] = 0; e_busy[r] = 0;
        end
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++) begin
                cm[i][j] = 0;
                for (int kk = 0; kk < k; kk++)
                    cm[i][j] += longint'(am[i*k+kk]) * longint'(bm[kk*n+j]);
            end
        t = 0;
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++)
                for (int kk = 0; kk < k; kk++) begin
                    e_rd[1+t]  = 1;
                    e_aa[1+t]  = i*k + kk;
                    e_ba[1+t]  = kk*n + j;
                    e_men[2+t] = 1;
                    e_clr[2+t] = (kk == 0) ? 1 : 0;
                    if (kk == k-1) begin
                        e_val[2+MAC_LAT+t] = 1;
                        e_row[2+MAC_LAT+t] = i;
                        e_col[2+MAC_LAT+t] = j;
                        e_dat[2+MAC_LAT+t] = cm[i][j];
                    end
                    t++;
                end
        nt = m*n*k;
        e_done[nt+2+MAC_LAT] = 1;
        for (int r = 1; r <= nt+1+MAC_LAT; r++) e_busy[r] = 1;
        r_end = nt + 3 + MAC_LAT;

        cfg_m = 3'(m);
        cfg_k = 3'(k);
        cfg_n = 3'(n);
        start = 1'b1;
        for (int r = 1; r <= r_end; r++) begin
            tick();
            start = poke && (r == 3);
            cfg_m = 3'($urandom);
            cfg_k = 3'($urandom);
            cfg_n = 3'($urandom);
            check("a_rd_en", longint'(a_rd_en), e_rd[r]);
            check("b_rd_en", longint'(b_rd_en), e_rd[r]);
            if (e_rd[r] != 0) begin
                check("a_rd_addr", longint'(a_rd_addr), e_aa[r]);
                check("b_rd_addr", longint'(b_rd_addr), e_ba[r]);
            end
            check("mac_en",    longint'(mac_en),    e_men[r]);
            check("mac_clear", longint'(mac_clear), e_clr[r]);
            check($sformatf("res_valid r%0d", r), longint'(res_valid), e_val[r]);
            if (e_val[r] != 0) begin
                check("res_row",  longint'(res_row), e_row[r]);
                check("res_col",  longint'(res_col), e_col[r]);
                check($sformatf("res_data r%0d", r), longint'($signed(res_data)), e_dat[r]);
            end
            check($sformatf("done r%0d", r), longint'(done), e_done[r]);
            check($sformatf("busy r%0d", r), longint'(busy), e_busy[r]);
            check("cfg_err", longint'(cfg_err), 0);
        end
        start = 1'b0;
    endtask

    // A rejected start: one cfg_err pulse, no activity.
    task automatic bad_start(input int m, input int k, input int n);
        cfg_m = 3'(m);
        cfg_k = 3'(k);
        cfg_n = 3'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("bad cfg_err pulse", longint'(cfg_err), 1);
        check("bad busy",          longint'(busy),    0);
        check("bad a_rd_en",       longint'(a_rd_en), 0);
        check("bad b_rd_en",       longint'(b_rd_en), 0);
        tick();
        check("bad cfg_err end",   longint'(cfg_err), 0);
        check("bad busy after",    longint'(busy),    0);
        check("bad a_rd_en after", longint'(a_rd_en), 0);
        check("bad mac_en after",  longint'(mac_en),  0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        cfg_m = '0;
        cfg_k = '0;
        cfg_n = '0;
        for (int x = 0; x < 16; x++) begin
            am[x] = '0;
            bm[x] = '0;
        end
        repeat (3) tick();
        rst = 1'b0;
        check_idle("reset");
        tick();

        // 1x1x1: 3 * -5
        am[0] = 16'sd3;
        bm[0] = -16'sd5;
        run_job(1, 1, 1, 1'b0);

        // 2x2x2 directed
        am[0] = 16'sd1; am[1] = 16'sd2; am[2] = 16'sd3; am[3] = 16'sd4;
        bm[0] = 16'sd5; bm[1] = 16'sd6; bm[2] = 16'sd7; bm[3] = 16'sd8;
        run_job(2, 2, 2, 1'b0);

        // Same job with a second start and config churn mid-run
        run_job(2, 2, 2, 1'b1);

        // 4x1x4: back-to-back results
        fill_rand();
        run_job(4, 1, 4, 1'b0);

        // Rejected configurations
        bad_start(2, 0, 2);
        bad_start(5, 2, 2);
        bad_start(2, 2, 0);
        bad_start(1, 7, 1);
        for (int x = 0; x < 3; x++) begin
            int d;
            int mm;
            int kk;
            int nn;
            d  = int'($urandom_range(0, 2));
            mm = int'($urandom_range(1, 4));
            kk = int'($urandom_range(1, 4));
            nn = int'($urandom_range(1, 4));
            if (d == 0) mm = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(5, 7));
            if (d == 1) kk = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(5, 7));
            if (d == 2) nn = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(5, 7));
            bad_start(mm, kk, nn);
        end

        // Reset during a 2x2x2 run
        am[0] = 16'sd1; am[1] = 16'sd2; am[2] = 16'sd3; am[3] = 16'sd4;
        bm[0] = 16'sd5; bm[1] = 16'sd6; bm[2] = 16'sd7; bm[3] = 16'sd8;
        cfg_m = 3'd2;
        cfg_k = 3'd2;
        cfg_n = 3'd2;
        start = 1'b1;
        for (int r = 1; r <= 6; r++) begin
            tick();
            start = 1'b0;
        end
        check("pre-reset busy", longint'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("mid-run reset");
        for (int r = 0; r < 10; r++) begin
            tick();
            check("post-reset res_valid", longint'(res_valid), 0);
            check("post-reset busy",      longint'(busy),      0);
            check("post-reset done",      longint'(done),      0);
        end
        run_job(2, 2, 2, 1'b0);

        // Extreme operands
        for (int x = 0; x < 16; x++) begin
            am[x] = -16'sd32768;
            bm[x] = -16'sd32768;
        end
        run_job(4, 4, 4, 1'b0);

        // Random dimensions and operands
        for (int x = 0; x < 8; x++) begin
            fill_rand();
            run_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                    int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
        end

        check_idle("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer that drives one pipelined MAC datapath to compute C = A x B for signed integer matrices held in two single-port, read-only operand memories.
- Walks the i/j/k loop nest and issues one dot-product term per cycle.
- Drives the MAC operand and accumulator-clear strobes, then tags each completed dot product with its (row, col) for the result sink.
- Sits between the matrix-load logic (operand memories, start/config) and the result buffer.

Parameters:
- DATA_W, 16: operand width; passed to the MAC.
- K_MAX, 4: maximum inner dimension; sets ACC_W = 2*DATA_W + $clog2(K_MAX) + 1.
- M_MAX, 4: maximum rows of A / C.
- N_MAX, 4: maximum columns of B / C.
- MAC_LAT, 2: cycles from operands presented at the MAC inputs to acc_out reflecting that term.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: 1-cycle request; dimensions are sampled in the same cycle.
- cfg_m, in, $clog2(M_MAX+1): rows of A.
- cfg_k, in, $clog2(K_MAX+1): columns of A / rows of B.
- cfg_n, in, $clog2(N_MAX+1): columns of B.
- a_rd_en, out, 1: A memory read strobe.
- a_rd_addr, out, $clog2(M_MAX*K_MAX): row-major address, i*K + k.
- b_rd_en, out, 1: B memory read strobe.
- b_rd_addr, out, $clog2(K_MAX*N_MAX): row-major address, k*N + j.
- mac_en, out, 1: operands on the MAC a_in/b_in are valid this cycle.
- mac_clear, out, 1: this term is k=0; accumulator loads the product instead of adding it. Drives MAC acc_clear.
- acc_out, in, ACC_W: MAC accumulator output.
- res_valid, out, 1: res_data holds the complete dot product for C[res_row][res_col].
- res_row, out, $clog2(M_MAX): row tag of the result.
- res_col, out, $clog2(N_MAX): column tag of the result.
- res_data, out, ACC_W: combinational passthrough of acc_out.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: 1-cycle pulse after the last result.
- cfg_err, out, 1: 1-cycle pulse when start is rejected.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all counters and the tag pipe cleared.
  - busy, done, cfg_err, rd_en, mac_en, mac_clear, res_valid = 0.
  - Addresses and tags = 0.
  - Reset mid-run aborts immediately. No partial results after reset.
- States:
  - IDLE -> RUN on an accepted start.
  - RUN -> DRAIN in the cycle after the last term is issued.
  - DRAIN -> DONE when the tag pipe is empty.
  - DONE -> IDLE unconditionally; done=1 in this state only.
- start acceptance: only in IDLE, and only if every dimension is in range.
  - Required: 1 <= cfg_m <= M_MAX, 1 <= cfg_k <= K_MAX, 1 <= cfg_n <= N_MAX.
  - Any dimension 0 or above its max: cfg_err pulses the next cycle and the state stays IDLE.
  - start outside IDLE is ignored (no error).
  - Dimensions are latched on acceptance; config input changes during a run have no effect.
- Issue (RUN): one term per cycle, no bubbles. k is the innermost loop, then j, then i.
  - Term n, 0-based, issues at cycle S+1+n, where S is the start cycle. a_rd_en = b_rd_en = 1 in those cycles.
  - Operand memories have 1-cycle read latency.
  - mac_en and mac_clear are the issue strobes delayed 1 cycle, so they align with the data at the MAC.
- Tag pipe: carries {valid, last, row, col}, delayed a total of 1+MAC_LAT cycles after issue.
  - res_valid = delayed valid & last, so the result for the term with k=K-1 appears at cycle S+2+MAC_LAT+n.
  - Consecutive results with K=1 are back-to-back, one per cycle.
- done asserts at cycle S+T+2+MAC_LAT, where T = M*N*K. busy falls in that same cycle.
- Address arithmetic uses the latched dimensions, computed incrementally (add K, or add N). No multipliers.
- No backpressure: the result sink must accept one result per cycle.

Decomposition:
- mac_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - function acc_w(DATA_W, K_MAX);
  - the tag struct type.
- Sub-module mac_tag_pipe: a parameterized-depth shift register of tags, cleared on rst.

Test Plan:
- M=N=K=1, MAC_LAT=2, A=[3], B=[-5], start at cycle 0 -> res_valid at cycle 4 with res_data=-15, row=0, col=0; done at cycle 5.
- M=N=K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start at cycle 0 -> res_valid at cycles 5, 7, 9, 11 with values 19, 22, 43, 50 and (row, col) = (0,0), (0,1), (1,0), (1,1); done at cycle 12.
- M=4, K=1, N=4 -> 16 consecutive res_valid cycles; mac_clear high on every mac_en cycle.
- start with cfg_k=0, then again with cfg_m=5 -> cfg_err pulses once per start; busy stays 0; no rd_en.
- Second start at cycle 3 of a run, with cfg inputs changed mid-run -> ignored; the original results are unchanged.
- rst at cycle 6 of the 2x2x2 run -> next cycle all outputs are 0 and state is IDLE; no res_valid follows; a new start completes correctly.
- Extreme operands: 4x4x4 with all elements -32768 -> every res_data = 4294967296, with no overflow at ACC_W=35.
